// File: rtl/otter_mem_arbiter_if.sv
// Bundles the requester and memory-side signals of otter_mem_arbiter.
// The slave modport is the arbiter. The master modport is the requesters plus the memory.
// ConflictCnt is present only when OTTER_ARB_PERF_EN is defined.
interface otter_mem_arbiter_if;
   logic        IfReq;
   logic [31:0] IfAddr;
   logic        IfGnt;
   logic        IfValid;
   logic [31:0] IfRdata;
   logic        DReq;
   logic        DWe;
   logic [31:0] DAddr;
   logic [31:0] DWdata;
   logic [3:0]  DBe;
   logic        DGnt;
   logic        DValid;
   logic [31:0] DRdata;
   logic        MemReq;
   logic        MemWe;
   logic        MemSel;
   logic [31:0] MemAddr;
   logic [31:0] MemWdata;
   logic [3:0]  MemBe;
   logic        MemReady;
   logic [31:0] MemRdata;
`ifdef OTTER_ARB_PERF_EN
   logic [31:0] ConflictCnt;
`endif

   modport slave (
      input  IfReq, IfAddr, DReq, DWe, DAddr, DWdata, DBe, MemReady, MemRdata,
      output IfGnt, IfValid, IfRdata, DGnt, DValid, DRdata,
             MemReq, MemWe, MemSel, MemAddr, MemWdata, MemBe
`ifdef OTTER_ARB_PERF_EN
      , output ConflictCnt
`endif
   );

   modport master (
      output IfReq, IfAddr, DReq, DWe, DAddr, DWdata, DBe, MemReady, MemRdata,
      input  IfGnt, IfValid, IfRdata, DGnt, DValid, DRdata,
             MemReq, MemWe, MemSel, MemAddr, MemWdata, MemBe
`ifdef OTTER_ARB_PERF_EN
      , input ConflictCnt
`endif
   );
endinterface

// File: rtl/otter_mem_arbiter.sv
// Shares the unified memory port between fetch (IF) and data (D) requesters. D has priority, and a streak limiter prevents IF starvation.
// Latency: the grant is combinational in IDLE, and xValid arrives one cycle after MemReady. Each access occupies at least 2 cycles.
// Backpressure: requests are held until their grant, and the FSM waits indefinitely on MemReady. Macro OTTER_ARB_PERF_EN adds ConflictCnt.
module otter_mem_arbiter #(
   parameter int MAX_D_STREAK = 4
) (
   input logic CLK,
   input logic RST_N,
   otter_mem_arbiter_if.slave bus
);
   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_BUSY_IF = 2'd1;
   localparam logic [1:0] ST_BUSY_D  = 2'd2;
   localparam logic [3:0] MAX_S      = 4'(MAX_D_STREAK);

   logic [1:0]  state_q, state_d;
   logic [3:0]  streak_q, streak_d;
   logic [31:0] addr_q, wdata_q, if_rdata_q, d_rdata_q;
   logic [3:0]  be_q;
   logic        we_q, if_valid_q, d_valid_q;
   logic        idle, if_force, if_gnt, d_gnt;

   // Grant decision: D wins ties unless the D streak has reached its limit
   always_comb begin
      idle     = (state_q == ST_IDLE);
      if_force = bus.IfReq && (streak_q == MAX_S);
      d_gnt    = idle && bus.DReq && !if_force;
      if_gnt   = idle && bus.IfReq && !d_gnt;
   end

   // Next state and streak: the streak counts D wins only while IF waits
   always_comb begin
      state_d  = state_q;
      streak_d = streak_q;
      case (state_q)
         ST_IDLE: begin
            if (d_gnt)       state_d = ST_BUSY_D;
            else if (if_gnt) state_d = ST_BUSY_IF;
         end
         ST_BUSY_IF, ST_BUSY_D: begin
            if (bus.MemReady) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      if (if_gnt)
         streak_d = 4'd0;
      else if (d_gnt && bus.IfReq && streak_q != MAX_S)
         streak_d = streak_q + 4'd1;
   end

   // FSM and streak registers
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q  <= ST_IDLE;
         streak_q <= 4'd0;
      end else begin
         state_q  <= state_d;
         streak_q <= streak_d;
      end
   end

   // Capture the winner's request so requesters can move on after the grant
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         be_q    <= 4'd0;
         we_q    <= 1'b0;
      end else if (d_gnt) begin
         addr_q  <= bus.DAddr;
         wdata_q <= bus.DWdata;
         be_q    <= bus.DBe;
         we_q    <= bus.DWe;
      end else if (if_gnt) begin
         addr_q  <= bus.IfAddr;
      end
   end

   // Completion: register read data and pulse Valid in the first IDLE cycle
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         if_valid_q <= 1'b0;
         d_valid_q  <= 1'b0;
         if_rdata_q <= 32'd0;
         d_rdata_q  <= 32'd0;
      end else begin
         if_valid_q <= (state_q == ST_BUSY_IF) && bus.MemReady;
         d_valid_q  <= (state_q == ST_BUSY_D) && bus.MemReady;
         if ((state_q == ST_BUSY_IF) && bus.MemReady)
            if_rdata_q <= bus.MemRdata;
         if ((state_q == ST_BUSY_D) && bus.MemReady && !we_q)
            d_rdata_q <= bus.MemRdata;
      end
   end

   assign bus.IfGnt    = if_gnt;
   assign bus.DGnt     = d_gnt;
   assign bus.IfValid  = if_valid_q;
   assign bus.DValid   = d_valid_q;
   assign bus.IfRdata  = if_rdata_q;
   assign bus.DRdata   = d_rdata_q;
   assign bus.MemReq   = !idle;
   assign bus.MemSel   = (state_q == ST_BUSY_D);
   assign bus.MemWe    = (state_q == ST_BUSY_D) && we_q;
   assign bus.MemAddr  = addr_q;
   assign bus.MemWdata = wdata_q;
   assign bus.MemBe    = be_q;

`ifdef OTTER_ARB_PERF_EN
   logic [31:0] conflict_q;
   logic        stalled;

   assign stalled = (bus.IfReq && !if_gnt) || (bus.DReq && !d_gnt);

   // Count cycles where at least one requester waits; wraps naturally
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N)       conflict_q <= 32'd0;
      else if (stalled) conflict_q <= conflict_q + 32'd1;
   end

   assign bus.ConflictCnt = conflict_q;
`endif
endmodule

// File: tb/tb_otter_mem_arbiter.sv
// Directed bench for otter_mem_arbiter.
// Inputs are driven on the falling edge, and outputs are checked 1ns later.
module tb_otter_mem_arbiter;
   logic CLK = 1'b0;
   logic RST_N = 1'b0;
   int   tests = 0;
   int   fails = 0;

   always #5 CLK = ~CLK;

   otter_mem_arbiter_if bus();

   otter_mem_arbiter #(.MAX_D_STREAK(4)) dut (
      .CLK   (CLK),
      .RST_N (RST_N),
      .bus   (bus)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      if (obs !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic nxt();
      @(negedge CLK);
   endtask

   logic ord [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

   initial begin
      int n;
      bus.IfReq = 0; bus.IfAddr = 0; bus.DReq = 0; bus.DWe = 0;
      bus.DAddr = 0; bus.DWdata = 0; bus.DBe = 0;
      bus.MemReady = 0; bus.MemRdata = 0;
      #3;
      check("rst_memreq", 32'(bus.MemReq), 0);
      check("rst_ifgnt", 32'(bus.IfGnt), 0);
      check("rst_memaddr", bus.MemAddr, 0);
      check("rst_ifrdata", bus.IfRdata, 0);
      nxt(); nxt();
      RST_N = 1;

      // IF-only fetch; memory completes in the 3rd busy cycle
      nxt();
      bus.IfReq = 1; bus.IfAddr = 32'h100;
      #1 check("if_gnt", 32'(bus.IfGnt), 1);
      check("if_no_dgnt", 32'(bus.DGnt), 0);
      for (int i = 0; i < 3; i++) begin
         nxt();
         bus.IfReq = 0;
         bus.MemReady = (i == 2); bus.MemRdata = 32'h13;
         #1 check($sformatf("if_busy_req%0d", i), 32'(bus.MemReq), 1);
         check($sformatf("if_busy_addr%0d", i), bus.MemAddr, 32'h100);
         check($sformatf("if_busy_sel%0d", i), 32'(bus.MemSel), 0);
         check($sformatf("if_busy_valid%0d", i), 32'(bus.IfValid), 0);
      end
      nxt();
      bus.MemReady = 0;
      #1 check("if_valid", 32'(bus.IfValid), 1);
      check("if_rdata", bus.IfRdata, 32'h13);
      check("if_done_memreq", 32'(bus.MemReq), 0);
      nxt();
      #1 check("if_valid_1cyc", 32'(bus.IfValid), 0);

      // Both requesters at once with a zero streak: the D write goes first
      bus.IfReq = 1; bus.IfAddr = 32'h104;
      bus.DReq = 1; bus.DWe = 1; bus.DAddr = 32'h2000; bus.DWdata = 32'hDEADBEEF; bus.DBe = 4'hF;
      bus.MemReady = 1; bus.MemRdata = 32'h55555555;
      #1 check("sim_dgnt", 32'(bus.DGnt), 1);
      check("sim_no_ifgnt", 32'(bus.IfGnt), 0);
      nxt();
      bus.DReq = 0; bus.DWe = 0; bus.DWdata = 0; bus.DBe = 0;
      #1 check("sim_memsel", 32'(bus.MemSel), 1);
      check("sim_memwe", 32'(bus.MemWe), 1);
      check("sim_memaddr", bus.MemAddr, 32'h2000);
      check("sim_memwdata", bus.MemWdata, 32'hDEADBEEF);
      check("sim_membe", 32'(bus.MemBe), 32'hF);
      check("sim_busy_ifgnt", 32'(bus.IfGnt), 0);
      nxt();
      #1 check("sim_dvalid", 32'(bus.DValid), 1);
      check("sim_drdata_kept", bus.DRdata, 0);
      check("sim_ifgnt_after", 32'(bus.IfGnt), 1);
      nxt();
      bus.IfReq = 0; bus.MemRdata = 32'h11111111;
      #1 check("sim_if_memwe", 32'(bus.MemWe), 0);
      check("sim_if_memaddr", bus.MemAddr, 32'h104);
      nxt();
      #1 check("sim_ifvalid", 32'(bus.IfValid), 1);
      check("sim_ifrdata", bus.IfRdata, 32'h11111111);

      // Starvation limit: both requests held, memory always ready
      bus.IfReq = 1; bus.DReq = 1; bus.DWe = 0; bus.MemReady = 1;
      n = 0;
      for (int c = 0; c < 40 && n < 10; c++) begin
         #1;
         if (bus.IfGnt && bus.DGnt) check("dual_gnt", 32'd1, 32'd0);
         if (bus.DGnt || bus.IfGnt) begin
            check($sformatf("order%0d", n), 32'(bus.DGnt), 32'(ord[n]));
            n++;
         end
         if (n < 10) nxt();
      end
      check("order_count", n, 10);
      nxt();
      bus.IfReq = 0; bus.DReq = 0;
      nxt();
      bus.MemReady = 0;
      #1 check("starve_last_ifvalid", 32'(bus.IfValid), 1);

      // Memory stall on a D read; a later IF request waits for completion
      bus.DReq = 1; bus.DWe = 0; bus.DAddr = 32'h3000;
      #1 check("stall_dgnt", 32'(bus.DGnt), 1);
      nxt();
      bus.DReq = 0; bus.IfReq = 1; bus.IfAddr = 32'h400;
      for (int i = 0; i < 10; i++) begin
         #1 check($sformatf("stall_memreq%0d", i), 32'(bus.MemReq), 1);
         check($sformatf("stall_gnts%0d", i), 32'({bus.IfGnt, bus.DGnt}), 0);
         if (i == 0) check("stall_memaddr", bus.MemAddr, 32'h3000);
         nxt();
      end
      bus.MemReady = 1; bus.MemRdata = 32'hCAFEF00D;
      #1 check("stall_no_early_valid", 32'(bus.DValid), 0);
      nxt();
      bus.MemReady = 0;
      #1 check("stall_dvalid", 32'(bus.DValid), 1);
      check("stall_drdata", bus.DRdata, 32'hCAFEF00D);
      check("stall_ifgnt", 32'(bus.IfGnt), 1);
      nxt();
      bus.IfReq = 0;
      #1 check("rst_mid_busy", 32'(bus.MemAddr), 32'h400);

      // Reset in the 2nd BUSY_IF cycle abandons the fetch
      nxt();
      RST_N = 0;
      #1 check("rst_async_memreq", 32'(bus.MemReq), 0);
      check("rst_async_ifrdata", bus.IfRdata, 0);
      bus.MemReady = 1;
      nxt(); nxt();
      RST_N = 1;
      nxt();
      #1 check("rst_no_ifvalid", 32'(bus.IfValid), 0);
      check("idle_ready_no_dvalid", 32'(bus.DValid), 0);
      check("rst_idle_memreq", 32'(bus.MemReq), 0);
      bus.MemReady = 0; bus.IfReq = 1; bus.IfAddr = 32'h200;
      #1 check("rst_fresh_ifgnt", 32'(bus.IfGnt), 1);
      nxt();
      bus.IfReq = 0; bus.MemReady = 1; bus.MemRdata = 32'h77;
      #1 check("rst_fresh_addr", bus.MemAddr, 32'h200);
      nxt();
      bus.MemReady = 0;
      #1 check("rst_fresh_valid", 32'(bus.IfValid), 1);
      check("rst_fresh_rdata", bus.IfRdata, 32'h77);

`ifdef OTTER_ARB_PERF_EN
      // Conflict counter: 5 IF-stalled cycles, then 3 cycles with both requesters stalled
      nxt();
      RST_N = 0;
      nxt();
      RST_N = 1;
      nxt();
      #1 check("perf_rst", bus.ConflictCnt, 0);
      bus.DReq = 1; bus.DWe = 0; bus.DAddr = 32'h40;
      nxt();
      bus.DReq = 0; bus.IfReq = 1;
      for (int i = 0; i < 5; i++) begin
         bus.MemReady = (i == 4);
         nxt();
      end
      bus.MemReady = 0;
      #1 check("perf_five", bus.ConflictCnt, 5);
      check("perf_ifgnt", 32'(bus.IfGnt), 1);
      nxt();
      bus.DReq = 1;
      for (int i = 0; i < 3; i++) begin
         bus.MemReady = (i == 2);
         nxt();
      end
      bus.MemReady = 0;
      #1 check("perf_both", bus.ConflictCnt, 8);
      nxt();
      bus.IfReq = 0; bus.DReq = 0; bus.MemReady = 1;
      nxt();
      bus.MemReady = 0;
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/otter_mem_arbiter.md
Name: otter_mem_arbiter

Overview:
- Shares the single-ported unified memory between the instruction-fetch requester (IF) and the data requester (D, from the MEM stage) of the pipelined OTTER core.
- Sequences each access with a 3-state FSM and drives the memory-side address/data selection, replacing the fixed 2:1 select.
- Default priority goes to D, the older instruction. A streak limiter prevents IF starvation.

Parameters:
- MAX_D_STREAK, 4: maximum consecutive D grants while IfReq is pending before IF is forced to win. Legal range is 1..15.

Ports:
- CLK  in  1  clock, rising-edge
- RST_N  in  1  asynchronous active-low reset
- IfReq  in  1  fetch request; held until IfGnt
- IfAddr  in  32  fetch address
- IfGnt  out  1  fetch accepted this cycle
- IfValid  out  1  one-cycle pulse; IfRdata valid
- IfRdata  out  32  fetched word
- DReq  in  1  data request; held until DGnt
- DWe  in  1  1 = write
- DAddr  in  32  data address
- DWdata  in  32  write data
- DBe  in  4  byte enables
- DGnt  out  1  data accepted this cycle
- DValid  out  1  one-cycle pulse; read data valid or write complete
- DRdata  out  32  read data
- MemReq  out  1  memory access active
- MemWe  out  1  memory write
- MemSel  out  1  0 = IF owns port, 1 = D owns port
- MemAddr  out  32  memory address
- MemWdata  out  32  memory write data
- MemBe  out  4  memory byte enables
- MemReady  in  1  memory completes access this cycle
- MemRdata  in  32  memory read data, valid with MemReady

Behaviour:
- Reset state (async, RST_N=0): FSM in IDLE. All outputs are 0 and the streak counter is 0. An in-flight access is abandoned, MemReq drops immediately, and no Valid is issued for it.
- FSM states and transitions:
  - IDLE → BUSY_IF or BUSY_D when a request is granted.
  - BUSY_x → IDLE on MemReady=1.
  - BUSY_x holds while MemReady=0; there is no timeout.
- Grant (combinational, IDLE only):
  - Only IfReq → IfGnt=1.
  - Only DReq → DGnt=1.
  - Both requesting → DGnt=1, unless streak==MAX_D_STREAK, in which case IfGnt=1.
  - Never both grants in one cycle. No grant outside IDLE.
- On a grant edge: latch the winner's address, and for D also We/Wdata/Be, into internal registers. Requesters may change their inputs after the grant cycle.
- Memory-side outputs:
  - In BUSY_x: MemReq=1, MemSel = (state==BUSY_D), and Mem* driven from the latched registers. MemWe=0 in BUSY_IF.
  - In IDLE: MemReq, MemWe and MemSel are 0; Mem* data holds its last value.
- Completion: MemReady=1 in BUSY_x registers MemRdata into xRdata and pulses xValid for exactly one cycle, the first IDLE cycle.
  - D writes pulse DValid but leave DRdata unchanged.
  - A new grant may occur in that same IDLE cycle.
  - Minimum occupancy is 2 cycles per access, giving back-to-back throughput of 1 access per 2 cycles.
- Streak counter (4-bit):
  - +1 on a DGnt where IfReq=1 in the same cycle.
  - Cleared on any IfGnt.
  - Unchanged on a DGnt where IfReq=0.
  - Saturates at MAX_D_STREAK.
- MemReady while in IDLE is ignored.
- xRdata holds its value until the next completing read for that requester.

Optional Feature:
- Macro: OTTER_ARB_PERF_EN
- Defined: adds output ConflictCnt (32-bit), cleared by reset. It increments by 1 each cycle in which a requester has its Req=1 and does not receive its Gnt. If both requesters are stalled in the same cycle it increments once. It wraps at 2^32.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- IF-only fetch: IfReq=1, IfAddr=0x100, with MemReady asserted 3 cycles into BUSY_IF and MemRdata=0x00000013 → IfGnt for 1 cycle, then MemReq=1, MemSel=0, MemAddr=0x100 for 3 cycles, then IfValid for 1 cycle with IfRdata=0x00000013.
- Simultaneous requests with streak=0: IfReq=DReq=1, DWe=1, DAddr=0x2000, DWdata=0xDEADBEEF, DBe=0xF, MemReady=1 immediately → DGnt first with MemSel=1, MemWe=1 and the Mem* values as given. DValid pulses and DRdata is unchanged. IfGnt follows in the next IDLE cycle only when DReq=0.
- Starvation limit: MAX_D_STREAK=4, IfReq and DReq held high continuously, MemReady=1 → grant order D,D,D,D,IF,D,D,D,D,IF; streak returns to 0 after each IfGnt.
- Memory stall: D read to 0x3000 with MemReady held low for 10 cycles → BUSY_D persists with MemReq=1 and no grants; a new IfReq is only granted after completion. DValid arrives 1 cycle after MemReady.
- Reset mid-access: drive RST_N=0 in the 2nd cycle of BUSY_IF → MemReq=0 asynchronously and no IfValid. After release, IDLE resumes and a fresh IfReq is granted normally.
- OTTER_ARB_PERF_EN defined: IfReq held high during 5 cycles of BUSY_D → ConflictCnt=5. Both requesters stalled for 3 cycles → +3, not +6.
